// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ACUMULA = 2'd1,
    AJUSTE  = 2'd2
  } estado_t;

  localparam int unsigned MAX_POS     = 8191;
  localparam int unsigned MAX_NEG_MAG = 8192;

  localparam logic [13:0] SAT_POS = 14'h1FFF;
  localparam logic [13:0] SAT_NEG = 14'h2000;

endpackage

// File: rtl/mac_decimal.sv
// One decimal accumulate step: acc*10 + digit, plus a flag for a non-BCD nibble.
module mac_decimal #(
  parameter int unsigned ANCHO = 14
) (
  input  logic [ANCHO-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ANCHO-1:0] resultado_c,
  output logic             invalido_c
);

  // acc*10 built from shifts so no multiplier is inferred
  assign resultado_c = (acc << 3) + (acc << 1) + ANCHO'(digit);
  assign invalido_c  = (digit > 4'd9);

endmodule

// File: rtl/bcd_a_binario.sv
// Sign + BCD digits to saturating two's-complement binary, one digit per cycle.
module bcd_a_binario
  import bcd_pkg::*;
#(
  parameter int unsigned ANCHO   = 14,
  parameter int unsigned DIGITOS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inicio,
  input  logic                 signo,
  input  logic [4*DIGITOS-1:0] digitos_bcd,
  output logic [ANCHO-1:0]     num_binario,
  output logic                 ocupado,
  output logic                 listo,
  output logic                 desborde,
  output logic                 error_digito
);

  localparam int unsigned IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  estado_t              state_q, state_d;
  logic                 signo_q, signo_d;
  logic [4*DIGITOS-1:0] digitos_q, digitos_d;
  logic [ANCHO-1:0]     acc_q, acc_d;
  logic [IW-1:0]        indice_q, indice_d;
  logic                 err_q, err_d;
  logic [ANCHO-1:0]     num_q, num_d;
  logic                 ocupado_q, ocupado_d;
  logic                 listo_q, listo_d;
  logic                 desborde_q, desborde_d;
  logic                 error_q, error_d;

  logic [3:0]           digito_c;
  logic [ANCHO-1:0]     mac_res_c;
  logic                 mac_inv_c;

  assign digito_c = digitos_q[{indice_q, 2'b00} +: 4];

  mac_decimal #(.ANCHO(ANCHO)) u_mac (
    .acc         (acc_q),
    .digit       (digito_c),
    .resultado_c (mac_res_c),
    .invalido_c  (mac_inv_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REPOSO;
      signo_q    <= 1'b0;
      digitos_q  <= '0;
      acc_q      <= '0;
      indice_q   <= '0;
      err_q      <= 1'b0;
      num_q      <= '0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      desborde_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      signo_q    <= signo_d;
      digitos_q  <= digitos_d;
      acc_q      <= acc_d;
      indice_q   <= indice_d;
      err_q      <= err_d;
      num_q      <= num_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      desborde_q <= desborde_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    signo_d    = signo_q;
    digitos_d  = digitos_q;
    acc_d      = acc_q;
    indice_d   = indice_q;
    err_d      = err_q;
    num_d      = num_q;
    ocupado_d  = ocupado_q;
    listo_d    = 1'b0;
    desborde_d = desborde_q;
    error_d    = error_q;

    unique case (state_q)
      REPOSO: begin
        if (inicio) begin
          signo_d   = signo;
          digitos_d = digitos_bcd;
          acc_d     = '0;
          indice_d  = IW'(DIGITOS - 1);
          err_d     = 1'b0;
          ocupado_d = 1'b1;
          state_d   = ACUMULA;
        end
      end
      ACUMULA: begin
        acc_d    = mac_res_c;
        err_d    = err_q | mac_inv_c;
        indice_d = indice_q - IW'(1);
        if (indice_q == '0) state_d = AJUSTE;
      end
      AJUSTE: begin
        // malformed input outranks saturation
        if (err_q) begin
          num_d      = '0;
          error_d    = 1'b1;
          desborde_d = 1'b0;
        end else if (!signo_q && (acc_q > ANCHO'(MAX_POS))) begin
          num_d      = ANCHO'(SAT_POS);
          error_d    = 1'b0;
          desborde_d = 1'b1;
        end else if (signo_q && (acc_q > ANCHO'(MAX_NEG_MAG))) begin
          num_d      = ANCHO'(SAT_NEG);
          error_d    = 1'b0;
          desborde_d = 1'b1;
        end else begin
          num_d      = signo_q ? (~acc_q + ANCHO'(1)) : acc_q;
          error_d    = 1'b0;
          desborde_d = 1'b0;
        end
        listo_d   = 1'b1;
        ocupado_d = 1'b0;
        state_d   = REPOSO;
      end
      default: state_d = REPOSO;
    endcase
  end

  assign num_binario  = num_q;
  assign ocupado      = ocupado_q;
  assign listo        = listo_q;
  assign desborde     = desborde_q;
  assign error_digito = error_q;

endmodule

// File: tb/tb_bcd_a_binario.sv
// Self-checking bench for bcd_a_binario: directed, boundary, random and protocol scenarios.
module tb_bcd_a_binario;

  logic        clk;
  logic        rst_n;
  logic        inicio;
  logic        signo;
  logic [15:0] digitos_bcd;
  logic [13:0] num_binario;
  logic        ocupado;
  logic        listo;
  logic        desborde;
  logic        error_digito;

  int total = 0;
  int bad   = 0;

  bcd_a_binario #(.ANCHO(14), .DIGITOS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inicio       (inicio),
    .signo        (signo),
    .digitos_bcd  (digitos_bcd),
    .num_binario  (num_binario),
    .ocupado      (ocupado),
    .listo        (listo),
    .desborde     (desborde),
    .error_digito (error_digito)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal value of the digits, then signed saturation in integer arithmetic.
  function automatic void modelo(input logic s, input logic [15:0] d,
                                 output logic [13:0] n, output logic ov, output logic er);
    int v;
    int r;
    logic [31:0] rv;
    logic [3:0] nib;
    v  = 0;
    er = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      nib = d[i*4 +: 4];
      if (nib > 4'd9) er = 1'b1;
      v = v * 10 + int'(nib);
    end
    ov = 1'b0;
    if (er) r = 0;
    else if (!s) begin
      if (v > 8191) begin r = 8191; ov = 1'b1; end else r = v;
    end else begin
      if (v > 8192) begin r = -8192; ov = 1'b1; end else r = -v;
    end
    if (er) ov = 1'b0;
    rv = 32'(r);
    n  = rv[13:0];
  endfunction

  // Drives one request and waits (bounded) for listo; lat counts edges after acceptance.
  task automatic convertir(input logic s, input logic [15:0] d,
                           output logic [13:0] n, output logic ov, output logic er,
                           output int lat, output logic busy_listo, output logic busy_n);
    @(negedge clk);
    inicio = 1'b1; signo = s; digitos_bcd = d;
    @(posedge clk); #1;
    busy_n = ocupado;
    @(negedge clk);
    inicio = 1'b0; signo = ~s; digitos_bcd = ~d;
    lat = 99; n = '0; ov = 1'b0; er = 1'b0; busy_listo = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (listo) begin
        lat = k; n = num_binario; ov = desborde; er = error_digito; busy_listo = ocupado;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inicio = 1'b0; signo = 1'b0; digitos_bcd = '0;
    #1;
    total++;
    if ({num_binario, ocupado, listo, desborde, error_digito} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs got num=%h ocu=%b lis=%b des=%b err=%b expected all 0",
               num_binario, ocupado, listo, desborde, error_digito);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ocupado, listo} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle got ocu=%b lis=%b expected 0 0", ocupado, listo);
    end
  endtask

  task automatic check_case(input string nombre, input logic s, input logic [15:0] d,
                            input logic [13:0] en, input logic eov, input logic eer);
    logic [13:0] n; logic ov, er, bl, bn; int lat;
    convertir(s, d, n, ov, er, lat, bl, bn);
    total++;
    if ({lat == 5, n, ov, er, bl, bn} !== {1'b1, en, eov, eer, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s s=%b d=%h got lat=%0d num=%h des=%b err=%b ocu_listo=%b ocu_n=%b expected lat=5 num=%h des=%b err=%b ocu_listo=0 ocu_n=1",
               nombre, s, d, lat, n, ov, er, bl, bn, en, eov, eer);
    end
  endtask

  task automatic test_basic();
    check_case("pos_1234",  1'b0, 16'h1234, 14'h04D2, 1'b0, 1'b0);
    check_case("neg_1234",  1'b1, 16'h1234, 14'h3B2E, 1'b0, 1'b0);
    check_case("neg_zero",  1'b1, 16'h0000, 14'h0000, 1'b0, 1'b0);
    check_case("pos_0007",  1'b0, 16'h0007, 14'h0007, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    check_case("pos_8191",  1'b0, 16'h8191, 14'h1FFF, 1'b0, 1'b0);
    check_case("pos_8192",  1'b0, 16'h8192, 14'h1FFF, 1'b1, 1'b0);
    check_case("neg_8192",  1'b1, 16'h8192, 14'h2000, 1'b0, 1'b0);
    check_case("neg_8193",  1'b1, 16'h8193, 14'h2000, 1'b1, 1'b0);
    check_case("neg_9999",  1'b1, 16'h9999, 14'h2000, 1'b1, 1'b0);
    check_case("pos_9999",  1'b0, 16'h9999, 14'h1FFF, 1'b1, 1'b0);
  endtask

  task automatic test_errors();
    check_case("err_12A4",  1'b0, 16'h12A4, 14'h0000, 1'b0, 1'b1);
    check_case("err_F999",  1'b1, 16'hF999, 14'h0000, 1'b0, 1'b1);
    check_case("err_000A",  1'b0, 16'h000A, 14'h0000, 1'b0, 1'b1);
    check_case("ok_after",  1'b0, 16'h0042, 14'h002A, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] d; logic s;
    logic [13:0] en; logic eov, eer;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) d = 16'($urandom);
      else for (int j = 0; j < 4; j++) d[j*4 +: 4] = 4'($urandom_range(0, 9));
      modelo(s, d, en, eov, eer);
      check_case("random", s, d, en, eov, eer);
    end
  endtask

  // inicio at N (A), ignored at N+2 (B), accepted in the listo cycle at N+6 (C).
  task automatic test_back_to_back();
    logic [13:0] n1, n2, ea, ec; logic x1, x2;
    int e1, e2, pulsos;
    modelo(1'b0, 16'h0321, ea, x1, x2);
    modelo(1'b1, 16'h0456, ec, x1, x2);
    e1 = -1; e2 = -1; pulsos = 0; n1 = '0; n2 = '0;
    @(negedge clk);
    inicio = 1'b1; signo = 1'b0; digitos_bcd = 16'h0321;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      inicio = (k == 2) || (k == 6);
      signo  = (k == 2) ? 1'b0 : 1'b1;
      digitos_bcd = (k == 2) ? 16'h0789 : 16'h0456;
      @(posedge clk); #1;
      if (listo) begin
        pulsos++;
        if (e1 < 0) begin e1 = k; n1 = num_binario; end
        else begin e2 = k; n2 = num_binario; end
      end
    end
    @(negedge clk);
    inicio = 1'b0;
    total++;
    if (e1 !== 5 || n1 !== ea) begin
      bad++;
      $display("FAIL b2b_first got edge=%0d num=%h expected edge=5 num=%h", e1, n1, ea);
    end
    total++;
    if (e2 !== 11 || n2 !== ec) begin
      bad++;
      $display("FAIL b2b_second got edge=%0d num=%h expected edge=11 num=%h", e2, n2, ec);
    end
    total++;
    if (pulsos !== 2) begin
      bad++;
      $display("FAIL b2b_pulses got %0d expected 2", pulsos);
    end
  endtask

  task automatic test_mid_reset();
    logic visto;
    check_case("pre_reset", 1'b0, 16'h0042, 14'h002A, 1'b0, 1'b0);
    @(negedge clk);
    inicio = 1'b1; signo = 1'b1; digitos_bcd = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({num_binario, ocupado, listo, desborde, error_digito} !== 18'd0) begin
      bad++;
      $display("FAIL midreset_outputs got num=%h ocu=%b lis=%b des=%b err=%b expected all 0",
               num_binario, ocupado, listo, desborde, error_digito);
    end
    visto = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (listo) visto = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (listo || ocupado) visto = 1'b1; end
    total++;
    if (visto !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_listo got activity=%b expected 0", visto);
    end
    check_case("post_reset", 1'b1, 16'h0500, 14'h3E0C, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_errors();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
